// File: rtl/writemg_n_pkg.sv
// rtl/writemg_n_pkg.sv - shared defaults and FSM state type for the merge-phase write-block controller
package writemg_n_pkg;

  localparam int DEF_WAY_LOG   = 2;
  localparam int DEF_SORT_ELM  = 4096;
  localparam int DEF_WBLOCKS   = 16;
  localparam int DEF_BLK_LOG   = 7;
  localparam int DEF_MIN_BLOCK = 1;
  localparam int DEF_ADDR_W    = 32;

  typedef enum logic [1:0] {
    FULL   = 2'd0,
    REDUCE = 2'd1,
    FLOOR  = 2'd2
  } wstate_t;

endpackage

// File: rtl/writemg_n_if.sv
// rtl/writemg_n_if.sv - merge-side control/status bundle between the write engine and writemg_n
interface writemg_n_if #(
  parameter int WAYS   = 4,
  parameter int ADDR_W = 32
);

  logic                   pchange;
  logic                   p_last;
  logic                   mgdrive;
  logic [31:0]            elem;
  logic [31:0]            elem_way;
  logic [31:0]            elem_plast;
  logic [ADDR_W-1:0]      w_addr;
  logic [31:0]            w_block;
  logic [WAYS*ADDR_W-1:0] r_endadr;
  logic [WAYS-1:0]        r_endvld;
  logic                   seg_done;

  modport master (
    output pchange, p_last, mgdrive, elem, elem_way, elem_plast, w_addr,
    input  w_block, r_endadr, r_endvld, seg_done
  );

  modport slave (
    input  pchange, p_last, mgdrive, elem, elem_way, elem_plast, w_addr,
    output w_block, r_endadr, r_endvld, seg_done
  );

endinterface

// File: rtl/writemg_bound.sv
// rtl/writemg_bound.sv - parallel segment-boundary comparators, one-hot hit per way
module writemg_bound
  import writemg_n_pkg::*;
#(
  parameter int WAY_LOG  = DEF_WAY_LOG,
  parameter int SORT_ELM = DEF_SORT_ELM
) (
  input  logic [31:0]              elem,
  input  logic                     p_last,
  output logic [(1<<WAY_LOG)-1:0]  hit
);

  localparam int          WAYS = 1 << WAY_LOG;
  localparam logic [31:0] SEG  = 32'(SORT_ELM >> WAY_LOG);

  // In pair-merge mode only every second boundary closes a (doubled) segment.
  for (genvar k = 1; k <= WAYS; k++) begin : g_cmp
    localparam logic [31:0] BND      = 32'(SEG * 32'(k));
    localparam logic        PAIR_END = ((k % 2) == 0);
    assign hit[k-1] = (elem == BND) && (!p_last || PAIR_END);
  end

endmodule

// File: rtl/writemg_n.sv
// rtl/writemg_n.sv - shrinks write bursts near segment ends and snapshots segment end addresses
module writemg_n
  import writemg_n_pkg::*;
#(
  parameter int WAY_LOG   = DEF_WAY_LOG,
  parameter int SORT_ELM  = DEF_SORT_ELM,
  parameter int WBLOCKS   = DEF_WBLOCKS,
  parameter int BLK_LOG   = DEF_BLK_LOG,
  parameter int MIN_BLOCK = DEF_MIN_BLOCK,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic        CLK,
  input  logic        RSTN,
  writemg_n_if.slave  bus
);

  localparam int          WAYS     = 1 << WAY_LOG;
  localparam logic [31:0] SEG      = 32'(SORT_ELM >> WAY_LOG);
  localparam logic [31:0] LEN_P    = SEG << 1;
  localparam logic [31:0] FULL_ELM = 32'(WBLOCKS << BLK_LOG);
  localparam logic [31:0] THR_N    = (FULL_ELM >= SEG)   ? 32'd0 : SEG - FULL_ELM;
  localparam logic [31:0] THR_P    = (FULL_ELM >= LEN_P) ? 32'd0 : LEN_P - FULL_ELM;
  localparam logic [31:0] WB       = 32'(WBLOCKS);
  localparam logic [31:0] MINB     = 32'(MIN_BLOCK);

  wstate_t                state_q, state_d;
  logic [31:0]            w_block_q, w_block_d;
  logic                   seg_done_q, seg_done_d;
  logic [ADDR_W-1:0]      adr_q [WAYS];
  logic [WAYS-1:0]        vld_q;
  logic [WAYS*ADDR_W-1:0] r_endadr_q;
  logic [WAYS-1:0]        r_endvld_q;

  logic [WAYS-1:0]        hit;
  logic [WAYS-1:0]        cap;
  logic [31:0]            cnt;
  logic [31:0]            thr;
  logic [31:0]            half;

  writemg_bound #(
    .WAY_LOG  (WAY_LOG),
    .SORT_ELM (SORT_ELM)
  ) u_bound (
    .elem   (bus.elem),
    .p_last (bus.p_last),
    .hit    (hit)
  );

  assign cnt  = bus.p_last ? bus.elem_plast : bus.elem_way;
  assign thr  = bus.p_last ? THR_P : THR_N;
  assign half = w_block_q >> 1;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= FULL;
      w_block_q  <= WB;
      seg_done_q <= 1'b0;
      vld_q      <= '0;
      r_endadr_q <= '0;
      r_endvld_q <= '0;
      for (int k = 0; k < WAYS; k++) adr_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      w_block_q  <= w_block_d;
      seg_done_q <= seg_done_d;
      if (bus.pchange) begin
        for (int k = 0; k < WAYS; k++) r_endadr_q[k*ADDR_W +: ADDR_W] <= adr_q[k];
        r_endvld_q <= vld_q;
        vld_q      <= '0;
      end else begin
        for (int k = 0; k < WAYS; k++) begin
          if (cap[k]) begin
            adr_q[k] <= bus.w_addr;
            vld_q[k] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.pchange || (|hit)) begin
      state_d = FULL;
    end else begin
      case (state_q)
        FULL:    if (cnt >= thr) state_d = REDUCE;
        REDUCE:  if (bus.mgdrive && half <= MINB) state_d = FLOOR;
        default: state_d = state_q;
      endcase
    end
  end

  // A boundary only records an end address if the segment actually ran short.
  always_comb begin
    w_block_d  = w_block_q;
    seg_done_d = 1'b0;
    cap        = '0;
    if (bus.pchange) begin
      w_block_d = WB;
    end else if (|hit) begin
      w_block_d  = WB;
      seg_done_d = 1'b1;
      if (state_q != FULL) cap = hit;
    end else if (state_q == REDUCE && bus.mgdrive) begin
      w_block_d = (half <= MINB) ? MINB : half;
    end
  end

  assign bus.w_block  = w_block_q;
  assign bus.seg_done = seg_done_q;
  assign bus.r_endadr = r_endadr_q;
  assign bus.r_endvld = r_endvld_q;

endmodule

// File: tb/tb_writemg_n.sv
// tb/tb_writemg_n.sv - directed plus randomized check of writemg_n against a behavioural model
module tb_writemg_n;

  localparam int WAY_LOG   = 2;
  localparam int WAYS      = 4;
  localparam int SORT_ELM  = 4096;
  localparam int WBLOCKS   = 4;
  localparam int BLK_LOG   = 7;
  localparam int MIN_BLOCK = 1;
  localparam int ADDR_W    = 32;
  localparam int SEG       = SORT_ELM / WAYS;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  writemg_n_if #(.WAYS(WAYS), .ADDR_W(ADDR_W)) bus ();

  writemg_n #(
    .WAY_LOG   (WAY_LOG),
    .SORT_ELM  (SORT_ELM),
    .WBLOCKS   (WBLOCKS),
    .BLK_LOG   (BLK_LOG),
    .MIN_BLOCK (MIN_BLOCK),
    .ADDR_W    (ADDR_W)
  ) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Model: "armed" means the segment has passed its threshold; wb is the burst size.
  logic [31:0] m_adr  [WAYS];
  bit          m_vld  [WAYS];
  logic [31:0] m_radr [WAYS];
  bit          m_rvld [WAYS];
  bit          m_armed;
  int unsigned m_wb;
  bit          m_sd;

  task automatic model_reset();
    for (int k = 0; k < WAYS; k++) begin
      m_adr[k] = '0; m_vld[k] = 0; m_radr[k] = '0; m_rvld[k] = 0;
    end
    m_armed = 0;
    m_wb    = WBLOCKS;
    m_sd    = 0;
  endtask

  function automatic int hit_way();
    longint unsigned e = bus.elem;
    longint unsigned k;
    if (e == 0 || (e % SEG) != 0) return -1;
    k = e / SEG;
    if (k > WAYS) return -1;
    if (bus.p_last && (k % 2) == 1) return -1;
    return int'(k) - 1;
  endfunction

  task automatic model_clk();
    int hk;
    longint unsigned len, fb, thr, cnt;
    len = bus.p_last ? 2 * SEG : SEG;
    fb  = longint'(WBLOCKS) * (1 << BLK_LOG);
    thr = (fb >= len) ? 0 : len - fb;
    cnt = bus.p_last ? bus.elem_plast : bus.elem_way;
    hk  = hit_way();
    if (bus.pchange) begin
      for (int k = 0; k < WAYS; k++) begin
        m_radr[k] = m_adr[k];
        m_rvld[k] = m_vld[k];
        m_vld[k]  = 0;
      end
      m_armed = 0; m_wb = WBLOCKS; m_sd = 0;
    end else if (hk >= 0) begin
      if (m_armed) begin
        m_adr[hk] = bus.w_addr;
        m_vld[hk] = 1;
      end
      m_armed = 0; m_wb = WBLOCKS; m_sd = 1;
    end else begin
      m_sd = 0;
      if (m_armed) begin
        if (bus.mgdrive && m_wb > MIN_BLOCK) m_wb = m_wb / 2;
      end else if (cnt >= thr) begin
        m_armed = 1;
      end
    end
  endtask

  task automatic compare_all();
    logic [127:0] ea;
    logic [3:0]   ev;
    for (int k = 0; k < WAYS; k++) begin
      ea[k*32 +: 32] = m_radr[k];
      ev[k]          = m_rvld[k];
    end
    check("w_block",  128'(bus.w_block),  128'(m_wb));
    check("seg_done", 128'(bus.seg_done), 128'(m_sd));
    check("r_endvld", 128'(bus.r_endvld), 128'(ev));
    check("r_endadr", 128'(bus.r_endadr), ea);
  endtask

  task automatic step();
    @(posedge clk);
    if (rstn) model_clk(); else model_reset();
    #2 compare_all();
  endtask

  task automatic drive(input bit pch, input bit pl, input bit mg, input int el,
                       input int ew, input int ep, input logic [31:0] wa);
    bus.pchange = pch; bus.p_last = pl; bus.mgdrive = mg;
    bus.elem = 32'(el); bus.elem_way = 32'(ew); bus.elem_plast = 32'(ep);
    bus.w_addr = wa;
    step();
  endtask

  task automatic mid_reset();
    #1 rstn = 1'b0;
    #1 model_reset();
    compare_all();
    check("rst_w_block",  128'(bus.w_block),  128'(WBLOCKS));
    check("rst_r_endvld", 128'(bus.r_endvld), 128'(0));
    @(negedge clk);
    rstn = 1'b1;
  endtask

  bit pl_r;

  initial begin
    model_reset();
    bus.pchange = 0; bus.p_last = 0; bus.mgdrive = 0;
    bus.elem = 0; bus.elem_way = 0; bus.elem_plast = 0; bus.w_addr = 0;
    step();
    @(negedge clk);
    rstn = 1'b1;

    for (int ew = 100; ew <= 600; ew += 100) drive(0, 0, 0, ew, ew, 0, 32'h0);
    drive(0, 0, 1, 650, 650, 0, 32'h0);
    check("tp2_half1", 128'(bus.w_block), 128'(2));
    drive(0, 0, 1, 660, 660, 0, 32'h0);
    check("tp2_half2", 128'(bus.w_block), 128'(1));
    drive(0, 0, 1, 670, 670, 0, 32'h0);
    check("tp2_floor", 128'(bus.w_block), 128'(1));
    drive(0, 0, 0, 1024, 670, 0, 32'h1A00);
    check("tp2_restore", 128'(bus.w_block), 128'(4));
    check("tp2_pulse", 128'(bus.seg_done), 128'(1));
    drive(0, 0, 0, 1100, 100, 0, 32'h0);
    check("tp2_pulse_end", 128'(bus.seg_done), 128'(0));

    drive(0, 0, 0, 2048, 100, 0, 32'h2200);
    check("tp3_pulse", 128'(bus.seg_done), 128'(1));

    drive(0, 1, 0, 1500, 0, 1600, 32'h0);
    drive(0, 1, 0, 1024, 0, 1600, 32'h1111);
    check("tp4_odd_nohit", 128'(bus.seg_done), 128'(0));
    drive(0, 1, 0, 2048, 0, 1700, 32'h3F00);
    check("tp4_pulse", 128'(bus.seg_done), 128'(1));

    drive(0, 0, 0, 2500, 600, 0, 32'h0);
    drive(0, 0, 1, 3072, 700, 0, 32'h5500);
    check("tp5_no_halve", 128'(bus.w_block), 128'(4));

    drive(1, 0, 0, 3100, 0, 0, 32'h0);
    check("tp6_vld_a", 128'(bus.r_endvld), 128'(4'b0111));
    check("tp6_adr_a", 128'(bus.r_endadr[95:0]), 128'(96'h00005500_00003F00_00001A00));

    drive(0, 0, 0, 500, 600, 0, 32'h0);
    drive(0, 0, 0, 1024, 600, 0, 32'h7000);
    drive(0, 0, 0, 1500, 600, 0, 32'h0);
    drive(0, 0, 0, 2048, 600, 0, 32'h7100);
    drive(0, 0, 0, 3500, 600, 0, 32'h0);
    drive(0, 0, 0, 4096, 600, 0, 32'h7300);
    drive(1, 0, 0, 4100, 0, 0, 32'h0);
    check("tp6_vld_b", 128'(bus.r_endvld), 128'(4'b1011));
    check("tp6_adr_b", 128'(bus.r_endadr), 128'h00007300_00005500_00007100_00007000);
    drive(0, 0, 0, 10, 10, 0, 32'h0);
    drive(1, 0, 0, 20, 20, 0, 32'h0);
    check("tp6_vld_c", 128'(bus.r_endvld), 128'(0));

    drive(0, 0, 0, 600, 600, 0, 32'h0);
    drive(0, 0, 1, 610, 610, 0, 32'h0);
    mid_reset();
    check("tp1_r_endadr", 128'(bus.r_endadr), 128'(0));
    check("tp1_seg_done", 128'(bus.seg_done), 128'(0));

    pl_r = 0;
    for (int i = 0; i < 3000; i++) begin
      int el;
      if ($urandom_range(0, 49) == 0) pl_r = ~pl_r;
      if ($urandom_range(0, 3) == 0) el = SEG * $urandom_range(1, 5);
      else                           el = $urandom_range(0, 5200);
      drive($urandom_range(0, 39) == 0, pl_r, $urandom_range(0, 1) == 1, el,
            $urandom_range(0, 1100), $urandom_range(0, 2200), $urandom);
      if ($urandom_range(0, 299) == 0) mid_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
